// File: rtl/sync_timing_if.sv
// Sync-decoder bundle: the incoming sync line plus the recovered timing results.
// The generator/checker side uses master; the decoder uses slave.
interface sync_timing_if #(
  parameter int PULSE_WIDTH   = 8,
  parameter int REZ_MAX_WIDTH = 12
);
  logic                     Sync_in;
  logic [REZ_MAX_WIDTH-1:0] Measured_max;
  logic [PULSE_WIDTH-1:0]   Measured_pulse;
  logic                     Meas_valid;
  logic                     Locked;
  logic [REZ_MAX_WIDTH-1:0] PositionP;
  logic                     Timing_err;

  modport master (
    output Sync_in,
    input  Measured_max, Measured_pulse, Meas_valid, Locked, PositionP, Timing_err
  );

  modport slave (
    input  Sync_in,
    output Measured_max, Measured_pulse, Meas_valid, Locked, PositionP, Timing_err
  );
endinterface

// File: rtl/sync_timing_decoder.sv
// Recovers period, pulse width, lock and a position counter from a single sync line.
// Optional SYNC_INPUT_CDC_EN adds two metastability flops ahead of the edge detector.
module sync_timing_decoder #(
  parameter int PULSE_WIDTH   = 8,
  parameter int REZ_MAX_WIDTH = 12,
  parameter int SYNC_ACTIVE   = 0,
  parameter int LOCK_COUNT    = 2
) (
  input  logic          Clk,
  input  logic          Rst,
  sync_timing_if.slave  tif
);
  localparam logic                     ACT      = 1'(SYNC_ACTIVE);
  localparam logic [REZ_MAX_WIDTH-1:0] PER_MAX  = '1;
  localparam logic [PULSE_WIDTH-1:0]   PW_MAX   = '1;
  localparam logic [3:0]               LOCK_TGT = 4'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t                   state, state_n;
  logic [3:0]               match_q, match_n, match_inc;
  logic                     sync_d, s0, s1;
  logic                     le, te, act;
  logic [REZ_MAX_WIDTH-1:0] per_q, pos_cur, per_p1;
  logic [PULSE_WIDTH-1:0]   pw_q, pw_nxt, pw_hold;
  logic [REZ_MAX_WIDTH-1:0] max_q;
  logic [PULSE_WIDTH-1:0]   pulse_q;
  logic                     cap, err_n, valid_q, err_q, ovf;

`ifdef SYNC_INPUT_CDC_EN
  logic [1:0] meta;
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) meta <= {2{~ACT}};
    else      meta <= {meta[0], tif.Sync_in};
  end
  assign sync_d = meta[1];
`else
  assign sync_d = tif.Sync_in;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s0 <= ~ACT;
      s1 <= ~ACT;
    end else begin
      s0 <= sync_d;
      s1 <= s0;
    end
  end

  assign act = (s0 == ACT);
  assign le  = act && (s1 != ACT);
  assign te  = !act && (s1 == ACT);

  // pos_cur is the position of the current cycle; per_q holds last cycle's value,
  // so on an LE cycle per_q is period-1.
  assign pos_cur = le ? '0 : ((per_q == PER_MAX) ? per_q : per_q + 1'b1);
  assign per_p1  = per_q + 1'b1;
  assign pw_nxt  = le ? PULSE_WIDTH'(1) :
                   (act && pw_q != PW_MAX) ? pw_q + 1'b1 : pw_q;
  assign ovf     = (per_q == PER_MAX) || (act && pw_q == PW_MAX);
  assign match_inc = (match_q == 4'hF) ? match_q : match_q + 4'd1;

  always_comb begin
    state_n = state;
    match_n = match_q;
    cap     = 1'b0;
    err_n   = 1'b0;
    case (state)
      SEARCH: if (le) state_n = MEASURE;
      MEASURE, LOCKED: begin
        // LE takes priority over a coincident saturation
        if (le) begin
          cap = 1'b1;
          if (per_p1 == max_q) begin
            match_n = match_inc;
            if (state == MEASURE && match_inc >= LOCK_TGT) state_n = LOCKED;
          end else begin
            match_n = 4'd0;
            if (state == LOCKED) begin
              err_n   = 1'b1;
              state_n = MEASURE;
            end
          end
        end else if (ovf) begin
          err_n   = 1'b1;
          match_n = 4'd0;
          state_n = SEARCH;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= SEARCH;
      match_q <= '0;
      per_q   <= '0;
      pw_q    <= '0;
      pw_hold <= '0;
      max_q   <= '0;
      pulse_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      match_q <= match_n;
      per_q   <= pos_cur;
      pw_q    <= pw_nxt;
      valid_q <= cap;
      err_q   <= err_n;
      if (te) pw_hold <= pw_q;
      if (cap) begin
        max_q   <= per_p1;
        pulse_q <= pw_hold;
      end
    end
  end

  assign tif.Measured_max   = max_q;
  assign tif.Measured_pulse = pulse_q;
  assign tif.Meas_valid     = valid_q;
  assign tif.Timing_err     = err_q;
  assign tif.Locked         = (state == LOCKED);
  assign tif.PositionP      = (state == SEARCH) ? '0 : pos_cur;
endmodule

// File: tb/tb_sync_timing_decoder.sv
// Scoreboarded bench for sync_timing_decoder: directed sync waveforms push expected
// capture/error events; a negedge monitor pops and compares them.
module tb_sync_timing_decoder;
  localparam int   PW  = 8;
  localparam int   RW  = 12;
  localparam logic ACT = 1'b0;
`ifdef SYNC_INPUT_CDC_EN
  localparam int   LAT = 4;
`else
  localparam int   LAT = 2;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  sync_timing_if #(.PULSE_WIDTH(PW), .REZ_MAX_WIDTH(RW)) tif ();

  sync_timing_decoder #(
    .PULSE_WIDTH(PW), .REZ_MAX_WIDTH(RW), .SYNC_ACTIVE(0), .LOCK_COUNT(2)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .tif(tif.slave)
  );

  typedef struct {
    logic          vld;
    logic [RW-1:0] mx;
    logic [PW-1:0] pw;
    logic          lk;
    logic          er;
    int            cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act_v, exp_v, cyc);
    end
  endtask

  task automatic push(input logic vld, input logic [RW-1:0] mx, input logic [PW-1:0] pw,
                      input logic lk, input logic er, input int ecyc);
    exp_t x;
    x.vld = vld; x.mx = mx; x.pw = pw; x.lk = lk; x.er = er; x.cyc = ecyc;
    q.push_back(x);
  endtask

  // monitor: every strobe must match the head of the scoreboard
  always @(negedge Clk) begin
    if (Rst && (tif.Meas_valid || tif.Timing_err)) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_strobe: got valid=%0b err=%0b want none (cycle %0d)",
                 tif.Meas_valid, tif.Timing_err, cyc);
      end else begin
        e = q.pop_front();
        chk("meas_valid",     32'(tif.Meas_valid),     32'(e.vld));
        chk("measured_max",   32'(tif.Measured_max),   32'(e.mx));
        chk("measured_pulse", 32'(tif.Measured_pulse), 32'(e.pw));
        chk("locked",         32'(tif.Locked),         32'(e.lk));
        chk("timing_err",     32'(tif.Timing_err),     32'(e.er));
        chk("latency_cycle",  32'(cyc),                32'(e.cyc));
      end
    end
  end

  // One sync period starting with an LE; called #1 after a rising edge.
  task automatic le_pulse(input int period, input int pulse, input bit do_push,
                          input logic [RW-1:0] mx, input logic [PW-1:0] pw,
                          input logic lk, input logic er, input bit pos_chk);
    int pmax;
    pmax = 0;
    tif.Sync_in = ACT;
    if (do_push) push(1'b1, mx, pw, lk, er, cyc + LAT);
    for (int j = 1; j <= period; j++) begin
      @(posedge Clk); #1;
      if (j == pulse) tif.Sync_in = ~ACT;
      if (pos_chk && j >= LAT - 1) begin
        if (int'(tif.PositionP) > pmax) pmax = int'(tif.PositionP);
        if (j == LAT - 1) chk("position_le", 32'(tif.PositionP), 32'd0);
        if (j == period)  chk("position_end", 32'(tif.PositionP), 32'(period - LAT + 1));
      end
    end
    if (pos_chk) chk("position_max", 32'(pmax), 32'(period - LAT + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tif.Sync_in = ~ACT;
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_valid",  32'(tif.Meas_valid),     32'd0);
    chk("rst_locked", 32'(tif.Locked),         32'd0);
    chk("rst_max",    32'(tif.Measured_max),   32'd0);
    chk("rst_pulse",  32'(tif.Measured_pulse), 32'd0);
    chk("rst_pos",    32'(tif.PositionP),      32'd0);
    chk("rst_err",    32'(tif.Timing_err),     32'd0);
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    // 1-clock pulse, period 8: lock on 3rd LE
    le_pulse(8, 1, 0, 0, 0, 0, 0, 0);
    le_pulse(8, 1, 1, 8, 1, 0, 0, 0);
    le_pulse(8, 1, 1, 8, 1, 1, 0, 0);
    le_pulse(8, 1, 1, 8, 1, 1, 0, 0);
    le_pulse(8, 1, 1, 8, 1, 1, 0, 0);
    chk("locked_after_p8", 32'(tif.Locked), 32'd1);

    // switch to 94/800: first full new period breaks lock, next one relocks
    le_pulse(800, 94, 1, 8,   1,  1, 0, 0);
    le_pulse(800, 94, 1, 800, 94, 0, 1, 0);
    le_pulse(800, 94, 1, 800, 94, 1, 0, 0);
    le_pulse(800, 94, 1, 800, 94, 1, 0, 1);

    // stuck asserted: pulse-width saturation 255 clocks after LE capture
    tif.Sync_in = ACT;
    n = cyc;
    push(1'b1, 800, 94, 1'b1, 1'b0, n + LAT);
    push(1'b0, 800, 94, 1'b0, 1'b1, n + LAT + 255);
    repeat (4096) @(posedge Clk);
    #1;
    tif.Sync_in = ~ACT;
    repeat (20) @(posedge Clk);
    #1;
    chk("stuck_locked", 32'(tif.Locked),         32'd0);
    chk("stuck_pos",    32'(tif.PositionP),      32'd0);
    chk("stuck_max",    32'(tif.Measured_max),   32'd800);
    chk("stuck_pulse",  32'(tif.Measured_pulse), 32'd94);

    // re-acquire from SEARCH; first capture equals held value so locks at once
    le_pulse(800, 94, 0, 0,   0,  0, 0, 0);
    le_pulse(800, 94, 1, 800, 94, 1, 0, 0);
    le_pulse(800, 94, 1, 800, 94, 1, 0, 1);
    repeat (10) @(posedge Clk);

    // async reset while locked
    #3;
    Rst = 1'b0;
    #1;
    chk("arst_locked", 32'(tif.Locked),         32'd0);
    chk("arst_max",    32'(tif.Measured_max),   32'd0);
    chk("arst_pulse",  32'(tif.Measured_pulse), 32'd0);
    chk("arst_valid",  32'(tif.Meas_valid),     32'd0);
    chk("arst_pos",    32'(tif.PositionP),      32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    le_pulse(16, 3, 0, 0,  0, 0, 0, 0);
    le_pulse(16, 3, 1, 16, 3, 0, 0, 0);
    le_pulse(16, 3, 1, 16, 3, 1, 0, 0);
    repeat (10) @(posedge Clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
